// File: rtl/fetch_pkg.sv
// Shared constants, defaults and FSM state type for the instruction fetch unit.
// FETCH_BOUND_CHECK_EN adds the OOB state used by the optional address bound check.
package fetch_pkg;

  localparam int unsigned DEF_PC_W    = 16;
  localparam int unsigned DEF_INSTR_W = 9;
  localparam int unsigned ROM_DEPTH   = 55;
  localparam logic [8:0]  HALT_OP     = 9'b111111111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
`ifdef FETCH_BOUND_CHECK_EN
    ,
    ST_OOB    = 2'd3
`endif
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register with next-PC selection (branch load, increment, hold).
// Increment wraps modulo 2^PC_W.
module pc_reg import fetch_pkg::*; #(
  parameter int unsigned PC_W     = DEF_PC_W,
  parameter int unsigned START_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_next_c;

  // Branch load wins over increment; otherwise hold.
  always_comb begin
    pc_next_c = pc;
    if (load) begin
      pc_next_c = target;
    end else if (inc) begin
      pc_next_c = pc + PC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= PC_W'(START_PC);
    end else begin
      pc <= pc_next_c;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Single-stage instruction fetch: drives ROM address from the PC register and registers
// the returned word. Optional FETCH_BOUND_CHECK_EN stops fetch at addresses >= ROM_DEPTH.
module fetch_unit import fetch_pkg::*; #(
  parameter int unsigned PC_W     = DEF_PC_W,
  parameter int unsigned INSTR_W  = DEF_INSTR_W,
  parameter int unsigned START_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    pc_out,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               stall,
  input  logic               branch_en,
  input  logic [PC_W-1:0]    branch_target,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  output logic               halted
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc;
  logic            pc_inc, pc_load, out_load, valid_d, halted_d;
  logic            is_halt_c;

  pc_reg #(
    .PC_W     (PC_W),
    .START_PC (START_PC)
  ) u_pc_reg (
    .clk    (clk),
    .reset  (reset),
    .inc    (pc_inc),
    .load   (pc_load),
    .target (branch_target),
    .pc     (pc)
  );

  assign pc_out    = pc;
  assign is_halt_c = (instr_in == INSTR_W'(HALT_OP));

`ifdef FETCH_BOUND_CHECK_EN
  logic oob_c;
  assign oob_c = (64'(pc) >= 64'(ROM_DEPTH));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, PC control and next values of the output registers.
  always_comb begin
    state_d  = state_q;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    out_load = 1'b0;
    valid_d  = instr_valid;
    halted_d = halted;
    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (branch_en) begin
          pc_load = 1'b1;
          valid_d = 1'b0;
        end else if (!stall) begin
`ifdef FETCH_BOUND_CHECK_EN
          if (oob_c) begin
            valid_d  = 1'b0;
            halted_d = 1'b1;
            state_d  = ST_OOB;
          end else
`endif
          begin
            out_load = 1'b1;
            valid_d  = 1'b1;
            if (is_halt_c) begin
              halted_d = 1'b1;
              state_d  = ST_HALTED;
            end else begin
              pc_inc = 1'b1;
            end
          end
        end
      end
      ST_HALTED: begin
        halted_d = 1'b1;
        if (!stall) begin
          valid_d = 1'b0;
        end
      end
`ifdef FETCH_BOUND_CHECK_EN
      ST_OOB: begin
        halted_d = 1'b1;
        valid_d  = 1'b0;
      end
`endif
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      if (out_load) begin
        instr_out <= instr_in;
        instr_pc  <= pc;
      end
      instr_valid <= valid_d;
      halted      <= halted_d;
    end
  end

endmodule
